// File: rtl/aclk_alarm_entry.sv
// Keypad alarm-time entry: collects four BCD digits (HH:MM, 24-hour), validates
// them, and issues a one-cycle load strobe with stable digits to the alarm register.
module aclk_alarm_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 2560,
  parameter int unsigned TMR_W          = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  input  logic       alarm_btn,
  input  logic       cancel_btn,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_alarm,
  output logic       entry_active,
  output logic       entry_error,
  output logic [2:0] digit_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             key_ok;
  logic             time_legal;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_ok     = 1'b0;
    time_legal = 1'b0;
    key_ok     = key_valid && (key_digit <= 4'd9) && (digit_count < 3'd4);
    time_legal = ((new_alarm_ms_hr < 4'd2 && new_alarm_ls_hr <= 4'd9) ||
                  (new_alarm_ms_hr == 4'd2 && new_alarm_ls_hr <= 4'd3)) &&
                 (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
  end

  assign entry_active = (state == S_ENTRY);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      timer            <= '0;
      digit_count      <= 3'd0;
      new_alarm_ms_hr  <= 4'd0;
      new_alarm_ls_hr  <= 4'd0;
      new_alarm_ms_min <= 4'd0;
      new_alarm_ls_min <= 4'd0;
      load_new_alarm   <= 1'b0;
      entry_error      <= 1'b0;
    end else begin
      load_new_alarm <= 1'b0;
      entry_error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alarm_btn) begin
            state            <= S_ENTRY;
            timer            <= '0;
            digit_count      <= 3'd0;
            new_alarm_ms_hr  <= 4'd0;
            new_alarm_ls_hr  <= 4'd0;
            new_alarm_ms_min <= 4'd0;
            new_alarm_ls_min <= 4'd0;
          end
        end
        S_ENTRY: begin
          // Cancel beats commit beats key beats timeout.
          if (cancel_btn) begin
            state <= S_IDLE;
          end else if (alarm_btn) begin
            if (digit_count == 3'd4 && time_legal) begin
              state          <= S_COMMIT;
              load_new_alarm <= 1'b1;
            end else begin
              state       <= S_ERROR;
              entry_error <= 1'b1;
            end
          end else if (key_ok) begin
            new_alarm_ms_hr  <= new_alarm_ls_hr;
            new_alarm_ls_hr  <= new_alarm_ms_min;
            new_alarm_ms_min <= new_alarm_ls_min;
            new_alarm_ls_min <= key_digit;
            digit_count      <= digit_count + 3'd1;
            timer            <= '0;
          end else if (timer == TIMER_LAST) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_COMMIT: state <= S_IDLE;
        S_ERROR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_alarm_entry.sv
// Self-checking bench for aclk_alarm_entry: directed scenarios followed by random
// keypad traffic, all compared every cycle against a digit-queue reference model.
module tb_aclk_alarm_entry;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_digit;
  logic       key_valid, alarm_btn, cancel_btn;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_alarm, entry_active, entry_error;
  logic [2:0] digit_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: accepted digits of the current entry, in entry order.
  int m_keys[$];
  bit m_active, m_busy, exp_load, exp_err;
  int m_quiet;
  int loads_seen, loads_exp;

  aclk_alarm_entry #(.TIMEOUT_CYCLES(TO), .TMR_W(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .key_digit       (key_digit),
    .key_valid       (key_valid),
    .alarm_btn       (alarm_btn),
    .cancel_btn      (cancel_btn),
    .new_alarm_ms_hr (ms_hr),
    .new_alarm_ls_hr (ls_hr),
    .new_alarm_ms_min(ms_min),
    .new_alarm_ls_min(ls_min),
    .load_new_alarm  (load_new_alarm),
    .entry_active    (entry_active),
    .entry_error     (entry_error),
    .digit_count     (digit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Digit position p (0 = ms_hr .. 3 = ls_min): the newest keys sit at the
  // right, with zeros padding the left until four have been entered.
  function automatic int exp_digit(int p);
    int n = m_keys.size();
    if (p >= 4 - n) return m_keys[p - (4 - n)];
    return 0;
  endfunction

  function automatic bit legal_time();
    int hh = 10 * m_keys[0] + m_keys[1];
    int mm = 10 * m_keys[2] + m_keys[3];
    return (hh < 24) && (mm < 60);
  endfunction

  task automatic model_reset();
    m_keys.delete();
    m_active = 0; m_busy = 0; m_quiet = 0;
    exp_load = 0; exp_err = 0;
  endtask

  task automatic model_step(bit kv, int kd, bit ab, bit cb);
    exp_load = 0;
    exp_err  = 0;
    if (m_busy) begin
      m_busy = 0;
    end else if (!m_active) begin
      if (ab) begin
        m_active = 1;
        m_keys.delete();
        m_quiet = 0;
      end
    end else if (cb) begin
      m_active = 0;
    end else if (ab) begin
      m_active = 0;
      m_busy   = 1;
      if (m_keys.size() == 4 && legal_time()) exp_load = 1;
      else exp_err = 1;
    end else if (kv && kd <= 9 && m_keys.size() < 4) begin
      m_keys.push_back(kd);
      m_quiet = 0;
    end else if (m_quiet == TO - 1) begin
      m_active = 0;
    end else begin
      m_quiet++;
    end
  endtask

  task automatic check_all();
    check("load_new_alarm", load_new_alarm, exp_load);
    check("entry_error", entry_error, exp_err);
    check("entry_active", entry_active, m_active);
    check("digit_count", digit_count, m_keys.size());
    check("ms_hr", ms_hr, exp_digit(0));
    check("ls_hr", ls_hr, exp_digit(1));
    check("ms_min", ms_min, exp_digit(2));
    check("ls_min", ls_min, exp_digit(3));
    if (load_new_alarm === 1'b1) loads_seen++;
    if (exp_load) loads_exp++;
  endtask

  task automatic step(bit kv, logic [3:0] kd, bit ab, bit cb);
    key_valid  = kv;
    key_digit  = kd;
    alarm_btn  = ab;
    cancel_btn = cb;
    @(posedge clock);
    model_step(kv, int'(kd), ab, cb);
    #1;
    check_all();
    key_valid  = 1'b0;
    alarm_btn  = 1'b0;
    cancel_btn = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0);
  endtask

  task automatic press_alarm();
    step(0, 4'd0, 1, 0);
  endtask

  task automatic key(logic [3:0] d);
    step(1, d, 0, 0);
  endtask

  task automatic entry4(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    press_alarm();
    key(a); key(b); key(c); key(d);
    press_alarm();
    idle(1);
  endtask

  initial begin
    loads_seen = 0;
    loads_exp  = 0;
    reset      = 1'b0;
    key_digit  = 4'd0;
    key_valid  = 1'b0;
    alarm_btn  = 1'b0;
    cancel_btn = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // Keys in IDLE are ignored.
    key(4'd5);
    check("idle_key_count", digit_count, 0);

    // Basic entry 07:30, then boundary times.
    entry4(4'd0, 4'd7, 4'd3, 4'd0);
    check("active_after_commit", entry_active, 0);
    entry4(4'd2, 4'd3, 4'd5, 4'd9);
    entry4(4'd0, 4'd0, 4'd0, 4'd0);
    entry4(4'd2, 4'd4, 4'd0, 4'd0);
    entry4(4'd1, 4'd9, 4'd6, 4'd0);

    // Three digits only.
    press_alarm();
    key(4'd1); key(4'd2); key(4'd3);
    press_alarm();
    idle(1);

    // Fifth digit and code 12 ignored; 12:34 commits.
    press_alarm();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd12);
    check("count_capped", digit_count, 4);
    press_alarm();
    // Second press in the COMMIT cycle is ignored; the next one starts a new entry.
    press_alarm();
    press_alarm();
    check("restart_clears", ms_hr, 0);
    step(0, 4'd0, 0, 1);

    // Cancel and alarm together after four keys: cancel wins.
    press_alarm();
    key(4'd1); key(4'd1); key(4'd1); key(4'd1);
    step(0, 4'd0, 1, 1);
    check("cancel_no_load", load_new_alarm, 0);
    idle(2);

    // Timeout: two keys, then TO quiet cycles.
    press_alarm();
    key(4'd1); key(4'd5);
    idle(TO - 1);
    check("active_before_timeout", entry_active, 1);
    idle(1);
    check("timeout_idle", entry_active, 0);
    press_alarm();
    check("post_timeout_no_load", load_new_alarm, 0);
    check("post_timeout_restart", digit_count, 0);
    step(0, 4'd0, 0, 1);

    // Reset asserted during the COMMIT cycle.
    press_alarm();
    key(4'd2); key(4'd1); key(4'd4); key(4'd5);
    press_alarm();
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // Random keypad traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 11)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    check("load_pulse_total", loads_seen, loads_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aclk_alarm_entry.md
# aclk_alarm_entry

Keypad-facing writer for the alarm-time register. Collects four BCD digits (HH:MM, 24-hour) from the keypad, validates them as a legal time, and issues a single-cycle `load_new_alarm` strobe together with stable `new_alarm_*` digits to the alarm register. It sits between the keypad decoder and the alarm register in the alarm clock top level. Invalid entries, cancels and idle timeouts never produce a load.

## Interface
- `TIMEOUT_CYCLES`, default 2560: clock cycles without an accepted key before an entry is abandoned.
- `TMR_W`, default 12: timeout counter width; must satisfy 2^TMR_W >= TIMEOUT_CYCLES.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `key_digit` input 4: digit from the keypad decoder; only codes 0-9 are accepted.
- `key_valid` input 1: one-cycle strobe qualifying `key_digit`.
- `alarm_btn` input 1: one-cycle strobe; starts an entry in IDLE and commits in ENTRY.
- `cancel_btn` input 1: one-cycle strobe; aborts the entry.
- `new_alarm_ms_hr`, `new_alarm_ls_hr`, `new_alarm_ms_min`, `new_alarm_ls_min` output 4 each: entry buffer digits, driven directly from registers.
- `load_new_alarm` output 1: registered, one-cycle commit strobe.
- `entry_active` output 1: high in ENTRY state.
- `entry_error` output 1: registered, one-cycle strobe on a rejected commit.
- `digit_count` output 3: accepted digits in the current entry, range 0-4.

## Operation
- States: IDLE, ENTRY, COMMIT, ERROR (binary encoded).
- Reset (`reset` low): state IDLE; all four digit outputs 0; `load_new_alarm`, `entry_error` and `entry_active` at 0; `digit_count` 0; timer 0.
- IDLE:
  - `alarm_btn` -> ENTRY. Buffer is cleared to 0000, `digit_count` to 0, timer to 0.
  - `key_valid` and `cancel_btn` are ignored.
- ENTRY: events are handled in strict priority order.
  - 1: `cancel_btn` -> IDLE. Buffer is kept, no load.
  - 2: `alarm_btn`. If `digit_count`==4 and the time is legal -> COMMIT, otherwise -> ERROR.
  - 3: `key_valid` with `key_digit`<=9 and `digit_count`<4. The buffer shifts left one digit: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key. `digit_count` increments and the timer clears.
  - A digit >9, or any digit when `digit_count`==4, is ignored and does not clear the timer.
  - 4: the timer reaches TIMEOUT_CYCLES-1 -> IDLE, no load. Otherwise the timer increments.
- Legal time: ms_hr<=2; ls_hr<=9 when ms_hr<2, ls_hr<=3 when ms_hr==2; ms_min<=5; ls_min<=9. 00:00 and 23:59 are legal; 24:00 is illegal.
- COMMIT: lasts one cycle, with `load_new_alarm`=1 during it, then -> IDLE.
- ERROR: lasts one cycle, with `entry_error`=1 during it, then -> IDLE.
- Digit outputs change only on a shift, on the clear at entry start, or on reset. They are stable in COMMIT and afterwards.

## Timing
- A key accepted at edge N is visible on the digit outputs and `digit_count` after edge N.
- A valid `alarm_btn` sampled at edge N sets `load_new_alarm` high from edge N to edge N+1. The alarm register captures the digits at edge N+1.
- Commit latency from the sampled `alarm_btn` is 1 cycle; the strobe width is exactly 1 cycle.
- A second `alarm_btn` during COMMIT or ERROR is ignored. The FSM is back in IDLE after that cycle, and a fresh press there starts a new entry.
- Timeout: with no accepted key since edge T, the FSM enters IDLE at edge T+TIMEOUT_CYCLES.
- Asynchronous reset asserted mid-entry or during COMMIT drops `load_new_alarm` immediately. No partial load is produced.

## Test plan
- Reset, then `alarm_btn`, keys 0,7,3,0, then `alarm_btn` -> exactly one `load_new_alarm` pulse with digits 0,7,3,0; `entry_active` low afterwards.
- Entries 23:59 and 00:00 -> load pulse; entries 24:00, 19:60 and 3-digit 1,2,3 -> `entry_error` one-cycle pulse and no load.
- Keys 1,2,3,4,5, key code 12, then commit -> digits 1,2,3,4; `digit_count` stays 4; load pulse.
- `cancel_btn` and `alarm_btn` in the same cycle after 4 keys -> IDLE, no load. `key_valid` in IDLE -> `digit_count` stays 0.
- TIMEOUT_CYCLES=16: start entry, 2 keys, 16 idle cycles -> IDLE with `entry_active` low. A later `alarm_btn` does not commit; it starts a new entry with buffer 0000.
- Assert `reset` low in the COMMIT cycle -> `load_new_alarm` goes to 0 asynchronously; all digit outputs 0.
